// File: rtl/kl_arbiter_3by1_rr.sv
// kl_arbiter_3by1_rr: three upstream request ports arbitrated round-robin onto one
// registered downstream request slot, with read-outstanding limiting per port and
// combinational routing of downstream responses back to the issuing port by dstid.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   upN_req_*   (N=0..2)      upstream request (addr/wen/wdata/wmask/size, valid/ready)
//   upN_resp_*  (N=0..2)      upstream response (rdata/valid out, ready in)
//   dn_req_*                  registered downstream request, srcid = SRCID_BASE | port
//   dn_resp_*                 downstream response, routed by dstid
module kl_arbiter_3by1_rr #(
  parameter int unsigned MAX_OUTST  = 2,
  parameter logic [4:0]  SRCID_BASE = 5'd0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [47:0] up0_req_addr,
  input  logic        up0_req_wen,
  input  logic [63:0] up0_req_wdata,
  input  logic [7:0]  up0_req_wmask,
  input  logic [2:0]  up0_req_size,
  input  logic        up0_req_valid,
  output logic        up0_req_ready,
  output logic [63:0] up0_resp_rdata,
  output logic        up0_resp_valid,
  input  logic        up0_resp_ready,

  input  logic [47:0] up1_req_addr,
  input  logic        up1_req_wen,
  input  logic [63:0] up1_req_wdata,
  input  logic [7:0]  up1_req_wmask,
  input  logic [2:0]  up1_req_size,
  input  logic        up1_req_valid,
  output logic        up1_req_ready,
  output logic [63:0] up1_resp_rdata,
  output logic        up1_resp_valid,
  input  logic        up1_resp_ready,

  input  logic [47:0] up2_req_addr,
  input  logic        up2_req_wen,
  input  logic [63:0] up2_req_wdata,
  input  logic [7:0]  up2_req_wmask,
  input  logic [2:0]  up2_req_size,
  input  logic        up2_req_valid,
  output logic        up2_req_ready,
  output logic [63:0] up2_resp_rdata,
  output logic        up2_resp_valid,
  input  logic        up2_resp_ready,

  output logic [47:0] dn_req_addr,
  output logic        dn_req_wen,
  output logic [63:0] dn_req_wdata,
  output logic [7:0]  dn_req_wmask,
  output logic [2:0]  dn_req_size,
  output logic [4:0]  dn_req_srcid,
  output logic        dn_req_valid,
  input  logic        dn_req_ready,

  input  logic [63:0] dn_resp_rdata,
  input  logic [2:0]  dn_resp_size,
  input  logic [4:0]  dn_resp_dstid,
  input  logic        dn_resp_valid,
  output logic        dn_resp_ready
);

  localparam logic [2:0] MaxOutst = 3'(MAX_OUTST);

  logic [2:0] up_valid, up_wen, up_resp_rdy, up_req_rdy;
  logic [2:0] elig, hit, inc, dec;

  assign up_valid    = {up2_req_valid, up1_req_valid, up0_req_valid};
  assign up_wen      = {up2_req_wen, up1_req_wen, up0_req_wen};
  assign up_resp_rdy = {up2_resp_ready, up1_resp_ready, up0_resp_ready};

  // Request slot and arbitration state
  logic [47:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  size_q, size_d;
  logic [4:0]  srcid_q, srcid_d;
  logic        valid_q, valid_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  cnt_q [3];
  logic [2:0]  cnt_d [3];

  logic        slot_free;
  logic        grant_vld;
  logic        grant_fire;
  logic [1:0]  grant_idx;
  logic [1:0]  order [3];

  assign slot_free = !valid_q || dn_req_ready;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      elig[n] = up_valid[n] && (up_wen[n] || (cnt_q[n] < MaxOutst));
    end
  end

  // Search order starts one past the last granted port.
  always_comb begin
    case (last_q)
      2'd0:    begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
      2'd1:    begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
      default: begin order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; end
    endcase
  end

  // Walk from lowest priority to highest so the highest-priority match is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (elig[order[k]]) begin
        grant_vld = 1'b1;
        grant_idx = order[k];
      end
    end
  end

  // Reset gating keeps upstream ready low while rst is held.
  assign grant_fire = !rst && slot_free && grant_vld;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      up_req_rdy[n] = grant_fire && (grant_idx == 2'(n));
    end
  end

  assign up0_req_ready = up_req_rdy[0];
  assign up1_req_ready = up_req_rdy[1];
  assign up2_req_ready = up_req_rdy[2];

  always_comb begin
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    srcid_d = srcid_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (grant_fire) begin
      valid_d = 1'b1;
      last_d  = grant_idx;
      srcid_d = SRCID_BASE | {3'b000, grant_idx};
      case (grant_idx)
        2'd1: begin
          addr_d  = up1_req_addr;
          wen_d   = up1_req_wen;
          wdata_d = up1_req_wdata;
          wmask_d = up1_req_wmask;
          size_d  = up1_req_size;
        end
        2'd2: begin
          addr_d  = up2_req_addr;
          wen_d   = up2_req_wen;
          wdata_d = up2_req_wdata;
          wmask_d = up2_req_wmask;
          size_d  = up2_req_size;
        end
        default: begin
          addr_d  = up0_req_addr;
          wen_d   = up0_req_wen;
          wdata_d = up0_req_wdata;
          wmask_d = up0_req_wmask;
          size_d  = up0_req_size;
        end
      endcase
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // Response decode: ids outside our base or with low bits 3 are dropped.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      hit[n] = (dn_resp_dstid[4:2] == SRCID_BASE[4:2]) && (dn_resp_dstid[1:0] == 2'(n));
    end
  end

  assign up0_resp_valid = dn_resp_valid && hit[0];
  assign up1_resp_valid = dn_resp_valid && hit[1];
  assign up2_resp_valid = dn_resp_valid && hit[2];
  assign up0_resp_rdata = dn_resp_rdata;
  assign up1_resp_rdata = dn_resp_rdata;
  assign up2_resp_rdata = dn_resp_rdata;
  assign dn_resp_ready  = (|hit) ? |(hit & up_resp_rdy) : 1'b1;

  // Outstanding-read counters; decrement saturates at zero.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      inc[n] = up_req_rdy[n] && !up_wen[n];
      dec[n] = dn_resp_valid && hit[n] && up_resp_rdy[n] && (cnt_q[n] != 3'd0);
      case ({inc[n], dec[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + 3'd1;
        2'b01:   cnt_d[n] = cnt_q[n] - 3'd1;
        default: cnt_d[n] = cnt_q[n];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      srcid_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 2'd2;
      for (int n = 0; n < 3; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      srcid_q <= srcid_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int n = 0; n < 3; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign dn_req_addr  = addr_q;
  assign dn_req_wen   = wen_q;
  assign dn_req_wdata = wdata_q;
  assign dn_req_wmask = wmask_q;
  assign dn_req_size  = size_q;
  assign dn_req_srcid = srcid_q;
  assign dn_req_valid = valid_q;

  logic unused_resp_size;
  assign unused_resp_size = ^dn_resp_size;

endmodule
